// File: rtl/tcdm_bank_array_pkg.sv
// Shared types and helpers for the TCDM bank array.
// Contents:
//   state_e   - states of the init/power FSM that all banks share
//   par_width - number of parity bits stored per word for a given data width
// Optional feature macro: TCDM_BANK_PARITY_EN (adds one even-parity bit per byte).
package tcdm_bank_array_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1,
    PWDN  = 2'd2
  } state_e;

  function automatic int unsigned par_width(input int unsigned data_width);
`ifdef TCDM_BANK_PARITY_EN
    return data_width / 8;
`else
    return 0;
`endif
  endfunction

endpackage

// File: rtl/tcdm_bank_array_if.sv
// Per-bank TCDM request/response bus.
// Signals (NB_BANKS lanes):
//   req_i, wen_i (1 = read), add_i (byte address), data_i, be_i  - master -> array
//   gnt_o, r_valid_o, r_data_o, err_o                            - array -> master
// Modports: master (requester side), slave (bank array side).
interface tcdm_bank_array_if #(
  parameter int unsigned NB_BANKS   = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NB_BANKS-1:0]                   req_i;
  logic [NB_BANKS-1:0]                   wen_i;
  logic [NB_BANKS-1:0][31:0]             add_i;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   data_i;
  logic [NB_BANKS-1:0][DATA_WIDTH/8-1:0] be_i;
  logic [NB_BANKS-1:0]                   gnt_o;
  logic [NB_BANKS-1:0]                   r_valid_o;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   r_data_o;
  logic [NB_BANKS-1:0]                   err_o;

  modport master (
    output req_i, wen_i, add_i, data_i, be_i,
    input  gnt_o, r_valid_o, r_data_o, err_o
  );

  modport slave (
    input  req_i, wen_i, add_i, data_i, be_i,
    output gnt_o, r_valid_o, r_data_o, err_o
  );
endinterface

// File: rtl/tc_sram.sv
// Single-port synchronous SRAM model with byte-lane write enables.
// Ports: clk_i, rst_ni (resets only the read pipeline), req_i, we_i,
//   addr_i (word index), wdata_i, be_i (one bit per ByteWidth lane), rdata_o.
// Read data appears Latency cycles after the request; storage is never reset.
module tc_sram #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  localparam int unsigned BeWidth   = DataWidth / ByteWidth,
  localparam int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic [DataWidth-1:0] rdata_o
);
  logic [DataWidth-1:0] mem [NumWords];
  logic [DataWidth-1:0] rdata_q [Latency];

  always_ff @(posedge clk_i) begin
    if (req_i && we_i) begin
      for (int j = 0; j < BeWidth; j++) begin
        if (be_i[j]) mem[addr_i][j*ByteWidth +: ByteWidth] <= wdata_i[j*ByteWidth +: ByteWidth];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) rdata_q[i] <= '0;
    end else begin
      if (req_i && !we_i) rdata_q[0] <= mem[addr_i];
      for (int i = 1; i < Latency; i++) rdata_q[i] <= rdata_q[i-1];
    end
  end

  assign rdata_o = rdata_q[Latency-1];
endmodule

// File: rtl/tcdm_bank_init_fsm.sv
// Shared INIT / READY / PWDN controller and init-sweep word counter.
// Ports: clk_i, rst_i (async, active-high), init_req_i (pulse), pwdn_i (level),
//   ready_o (user access allowed), sweep_o (sweep write this cycle), cnt_o (sweep word).
module tcdm_bank_init_fsm
  import tcdm_bank_array_pkg::*;
#(
  parameter int unsigned BANK_SIZE = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         init_req_i,
  input  logic                         pwdn_i,
  output logic                         ready_o,
  output logic                         sweep_o,
  output logic [$clog2(BANK_SIZE)-1:0] cnt_o
);
  localparam int unsigned CNT_W = $clog2(BANK_SIZE);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Power-down wins over a re-init request; every entry into INIT starts at word 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (pwdn_i) begin
          state_d = PWDN;
          cnt_d   = '0;
        end else if (init_req_i) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(BANK_SIZE - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (pwdn_i) begin
          state_d = PWDN;
        end else if (init_req_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      PWDN: begin
        if (!pwdn_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ready_o = (state_q == READY);
    sweep_o = (state_q == INIT);
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/tcdm_bank_array.sv
// Array of NB_BANKS independent single-port word banks behind one shared
// init/power FSM. After reset, an init request, or leaving power-down, every
// bank is swept with INIT_VALUE before user access is granted.
// Ports: clk_i, rst_i (async, active-high), init_req_i, pwdn_i, ready_o,
//   bus (tcdm_bank_array_if.slave: req/wen/add/data/be in, gnt/r_valid/r_data/err out).
// Optional feature macro: TCDM_BANK_PARITY_EN - one even-parity bit stored per
//   byte, checked on every read and reported on err_o alongside r_valid_o.
module tcdm_bank_array
  import tcdm_bank_array_pkg::*;
#(
  parameter int unsigned          NB_BANKS   = 16,
  parameter int unsigned          BANK_SIZE  = 256,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_req_i,
  input  logic              pwdn_i,
  output logic              ready_o,
  tcdm_bank_array_if.slave  bus
);
  localparam int unsigned NB_BYTES = DATA_WIDTH / 8;
  localparam int unsigned PAR_W    = par_width(DATA_WIDTH);
  localparam int unsigned BYTE_W   = 8 + PAR_W / NB_BYTES;
  localparam int unsigned SRAM_W   = DATA_WIDTH + PAR_W;
  localparam int unsigned IDX_W    = $clog2(BANK_SIZE);
  localparam int unsigned OFF_W    = $clog2(NB_BYTES);

  // Stored layout: each byte lane is BYTE_W wide, data in the low 8 bits,
  // parity (when present) in the bit above.
  function automatic logic [SRAM_W-1:0] pack_word(input logic [DATA_WIDTH-1:0] d);
    logic [SRAM_W-1:0] w;
    w = '0;
    for (int j = 0; j < NB_BYTES; j++) begin
      w[j*BYTE_W +: 8] = d[j*8 +: 8];
`ifdef TCDM_BANK_PARITY_EN
      w[j*BYTE_W + 8] = ^d[j*8 +: 8];
`endif
    end
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] unpack_word(input logic [SRAM_W-1:0] w);
    logic [DATA_WIDTH-1:0] d;
    for (int j = 0; j < NB_BYTES; j++) d[j*8 +: 8] = w[j*BYTE_W +: 8];
    return d;
  endfunction

`ifdef TCDM_BANK_PARITY_EN
  function automatic logic parity_err(input logic [SRAM_W-1:0] w);
    logic e;
    e = 1'b0;
    for (int j = 0; j < NB_BYTES; j++) e = e | (^w[j*BYTE_W +: BYTE_W]);
    return e;
  endfunction
`endif

  logic                ready;
  logic                sweep;
  logic [IDX_W-1:0]    sweep_idx;
  logic [NB_BANKS-1:0] rvld_p1;
  logic                add_unused;

  // Address bits above the word index are don't-care.
  assign add_unused = ^bus.add_i;

  tcdm_bank_init_fsm #(
    .BANK_SIZE (BANK_SIZE)
  ) i_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .init_req_i (init_req_i),
    .pwdn_i     (pwdn_i),
    .ready_o    (ready),
    .sweep_o    (sweep),
    .cnt_o      (sweep_idx)
  );

  assign ready_o   = ready;
  assign bus.gnt_o = ready ? bus.req_i : '0;

  // ---- stage p0 -> p1: granted reads return data one cycle later ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rvld_p1 <= '0;
    else       rvld_p1 <= bus.gnt_o & bus.wen_i;
  end

  assign bus.r_valid_o = rvld_p1;

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic                bank_req;
    logic                bank_we;
    logic [IDX_W-1:0]    bank_addr;
    logic [SRAM_W-1:0]   bank_wdata;
    logic [NB_BYTES-1:0] bank_be;
    logic [SRAM_W-1:0]   bank_rdata;

    always_comb begin
      bank_req   = 1'b0;
      bank_we    = 1'b0;
      bank_addr  = sweep_idx;
      bank_wdata = pack_word(INIT_VALUE);
      bank_be    = '1;
      if (sweep) begin
        bank_req = 1'b1;
        bank_we  = 1'b1;
      end else if (ready) begin
        bank_req   = bus.req_i[b];
        bank_we    = ~bus.wen_i[b];
        bank_addr  = bus.add_i[b][IDX_W+OFF_W-1:OFF_W];
        bank_wdata = pack_word(bus.data_i[b]);
        bank_be    = bus.be_i[b];
      end
    end

    tc_sram #(
      .NumWords  (BANK_SIZE),
      .DataWidth (SRAM_W),
      .ByteWidth (BYTE_W),
      .Latency   (1)
    ) i_sram (
      .clk_i   (clk_i),
      .rst_ni  (~rst_i),
      .req_i   (bank_req),
      .we_i    (bank_we),
      .addr_i  (bank_addr),
      .wdata_i (bank_wdata),
      .be_i    (bank_be),
      .rdata_o (bank_rdata)
    );

    assign bus.r_data_o[b] = unpack_word(bank_rdata);
`ifdef TCDM_BANK_PARITY_EN
    assign bus.err_o[b] = rvld_p1[b] & parity_err(bank_rdata);
`else
    assign bus.err_o[b] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_tcdm_bank_array.sv
module tb_tcdm_bank_array;
  localparam int NB = 4;
  localparam int BS = 16;
  localparam int DW = 32;
  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_req = 1'b0;
  logic pwdn = 1'b0;
  logic ready;

  tcdm_bank_array_if #(.NB_BANKS(NB), .DATA_WIDTH(DW)) bus ();

  tcdm_bank_array #(
    .NB_BANKS (NB), .BANK_SIZE (BS), .DATA_WIDTH (DW), .INIT_VALUE (IV)
  ) dut (
    .clk_i (clk), .rst_i (rst), .init_req_i (init_req), .pwdn_i (pwdn),
    .ready_o (ready), .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents, corrupted-byte marks, and operating phase.
  typedef enum {M_SWEEP, M_READY, M_PWDN} mphase_e;
  typedef struct {int due; logic [31:0] data; logic err;} exp_t;

  logic [31:0] mem_m [NB][BS];
  logic [3:0]  bad_m [NB][BS];
  mphase_e     ph = M_SWEEP;
  int          sweep_n = 0;
  exp_t        q [NB][$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every read-valid must match the oldest expected response due now.
  always @(negedge clk) begin : mon
    exp_t e;
    logic pend;
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        pend = (q[b].size() > 0) && (q[b][0].due == cyc);
        if (bus.r_valid_o[b] || pend) begin
          chk($sformatf("r_valid_o[%0d]", b), 64'(bus.r_valid_o[b]), 64'(pend));
          if (pend) begin
            e = q[b].pop_front();
            if (bus.r_valid_o[b]) begin
              chk($sformatf("r_data_o[%0d]", b), 64'(bus.r_data_o[b]), 64'(e.data));
              chk($sformatf("err_o[%0d]", b), 64'(bus.err_o[b]), 64'(e.err));
            end
          end
        end
      end
    end
  end

  // One bus cycle: drive, predict, check grant/ready, advance the model.
  task automatic cycle(input logic [NB-1:0] req, input logic [NB-1:0] wen,
                       input logic [NB-1:0][31:0] add, input logic [NB-1:0][31:0] data,
                       input logic [NB-1:0][3:0] be, input logic p, input logic ir);
    logic rdy;
    int w;
    exp_t e;
    bus.req_i = req; bus.wen_i = wen; bus.add_i = add; bus.data_i = data; bus.be_i = be;
    pwdn = p; init_req = ir;
    rdy = (ph == M_READY);
    if (rdy) begin
      for (int b = 0; b < NB; b++) begin
        if (req[b]) begin
          w = int'(add[b][5:2]);
          if (wen[b]) begin
            e.due = cyc + 1; e.data = mem_m[b][w]; e.err = |bad_m[b][w];
            q[b].push_back(e);
          end else begin
            for (int j = 0; j < 4; j++) begin
              if (be[b][j]) begin
                mem_m[b][w][j*8 +: 8] = data[b][j*8 +: 8];
                bad_m[b][w][j] = 1'b0;
              end
            end
          end
        end
      end
    end
    @(negedge clk);
    chk("ready_o", 64'(ready), 64'(rdy));
    chk("gnt_o", 64'(bus.gnt_o), rdy ? 64'(req) : 64'(0));
    case (ph)
      M_READY: begin
        if (p) ph = M_PWDN;
        else if (ir) begin ph = M_SWEEP; sweep_n = 0; end
      end
      M_SWEEP: begin
        if (p) ph = M_PWDN;
        else if (ir) sweep_n = 0;
        else if (sweep_n == BS - 1) begin
          ph = M_READY;
          for (int b = 0; b < NB; b++)
            for (int i = 0; i < BS; i++) begin mem_m[b][i] = IV; bad_m[b][i] = '0; end
        end else sweep_n++;
      end
      default: if (!p) begin ph = M_SWEEP; sweep_n = 0; end
    endcase
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic p, input logic ir);
    cycle('0, '0, '0, '0, '0, p, ir);
  endtask

  // Requests on every bank while access should be blocked.
  task automatic blocked(input logic p, input logic ir);
    cycle('1, '1, '0, '0, '0, p, ir);
  endtask

  task automatic rd1(input int b, input logic [31:0] a);
    logic [NB-1:0] rq;
    logic [NB-1:0][31:0] ad;
    rq = '0; ad = '0; rq[b] = 1'b1; ad[b] = a;
    cycle(rq, '1, ad, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr1(input int b, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [NB-1:0] rq;
    logic [NB-1:0][31:0] ad, dt;
    logic [NB-1:0][3:0] bb;
    rq = '0; ad = '0; dt = '0; bb = '0;
    rq[b] = 1'b1; ad[b] = a; dt[b] = d; bb[b] = be;
    cycle(rq, '0, ad, dt, bb, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '1; bus.wen_i = '1;
    pwdn = 1'b0; init_req = 1'b0;
    for (int b = 0; b < NB; b++) q[b].delete();
    @(negedge clk);
    chk("rst ready_o", 64'(ready), 64'(0));
    chk("rst gnt_o", 64'(bus.gnt_o), 64'(0));
    chk("rst r_valid_o", 64'(bus.r_valid_o), 64'(0));
    chk("rst err_o", 64'(bus.err_o), 64'(0));
    chk("rst r_data_o", 64'(|bus.r_data_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; bus.req_i = '0;
    ph = M_SWEEP; sweep_n = 0;
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (ph != M_READY && n < bound) begin blocked(1'b0, 1'b0); n++; end
    chk("ready within bound", 64'(ready), 64'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : stim
    logic [NB-1:0] rq, wn;
    logic [NB-1:0][31:0] ad, dt;
    logic [NB-1:0][3:0] bb;
    bus.req_i = '0; bus.wen_i = '0; bus.add_i = '0; bus.data_i = '0; bus.be_i = '0;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < BS; i++) begin mem_m[b][i] = 'x; bad_m[b][i] = '0; end
    @(posedge clk); #1;
    do_reset();

    // Sweep: exactly BS cycles with no grants, then ready.
    for (int i = 0; i < BS; i++) blocked(1'b0, 1'b0);
    rd1(2, 32'h0000_003C);

    // Partial write then read back.
    wr1(1, 32'h0000_0008, 32'h1234_5678, 4'b0101);
    rd1(1, 32'h0000_0008);

    // Random traffic, full-width addresses so the ignored upper bits toggle.
    for (int i = 0; i < 200; i++) begin
      rq = NB'($urandom); wn = NB'($urandom);
      for (int b = 0; b < NB; b++) begin
        ad[b] = $urandom; dt[b] = $urandom; bb[b] = 4'($urandom);
      end
      cycle(rq, wn, ad, dt, bb, 1'b0, 1'b0);
    end

    // All banks read back-to-back over every word.
    for (int i = 0; i < BS; i++) begin
      for (int b = 0; b < NB; b++) ad[b] = 32'(i * 4);
      cycle('1, '1, ad, '0, '0, 1'b0, 1'b0);
    end

    // Re-init with a write in the same cycle, restarted mid-sweep.
    rq = '0; ad = '0; dt = '0; bb = '0;
    rq[3] = 1'b1; ad[3] = 32'h14; dt[3] = 32'hDEAD_BEEF; bb[3] = 4'hF;
    cycle(rq, '0, ad, dt, bb, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) blocked(1'b0, 1'b0);
    blocked(1'b0, 1'b1);
    wait_ready(40);
    rd1(3, 32'h14);

    // Power-down: read served on the entry cycle, then blocked through re-sweep.
    wr1(1, 32'h0000_0008, 32'h0BAD_F00D, 4'hF);
    rd1(1, 32'h0000_0008);
    rq = '0; ad = '0; rq[0] = 1'b1; ad[0] = 32'h8;
    cycle(rq, '1, ad, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) blocked(1'b1, 1'b0);
    wait_ready(40);
    rd1(1, 32'h0000_0008);

    // Reset in the middle of a sweep restarts it from word 0.
    do_reset();
    for (int i = 0; i < 7; i++) blocked(1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < BS; i++) blocked(1'b0, 1'b0);
    rd1(0, 32'h0);

`ifdef TCDM_BANK_PARITY_EN
    dut.g_bank[0].i_sram.mem[3][9] = ~dut.g_bank[0].i_sram.mem[3][9];
    mem_m[0][3][8] = ~mem_m[0][3][8];
    bad_m[0][3][1] = 1'b1;
    rd1(0, 32'h0000_000C);
    rd1(0, 32'h0000_0010);
`endif

    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    for (int b = 0; b < NB; b++) chk($sformatf("queue drained[%0d]", b), 64'(q[b].size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tcdm_bank_array.md
TCDM_BANK_ARRAY -- requirements
Module: tcdm_bank_array

Interface
REQ-001 SHALL have parameter NB_BANKS, default 16, number of independent banks.
REQ-002 SHALL have parameter BANK_SIZE, default 256, words per bank, power of two, >=16.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, bits per word, multiple of 8, 32 or 64.
REQ-004 SHALL have parameter INIT_VALUE, default '0, DATA_WIDTH-bit word written during init sweep.
REQ-005 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port init_req_i  input  1  single-cycle request to re-run init sweep.
REQ-008 SHALL have port pwdn_i  input  1  power-down request, level.
REQ-009 SHALL have port req_i  input  [NB_BANKS]  per-bank request.
REQ-010 SHALL have port wen_i  input  [NB_BANKS]  per-bank write-enable, active-low (1 = read).
REQ-011 SHALL have port add_i  input  [NB_BANKS][32]  per-bank byte address.
REQ-012 SHALL have port data_i  input  [NB_BANKS][DATA_WIDTH]  write data.
REQ-013 SHALL have port be_i  input  [NB_BANKS][DATA_WIDTH/8]  byte enables.
REQ-014 SHALL have port gnt_o  output  [NB_BANKS]  grant.
REQ-015 SHALL have port r_valid_o  output  [NB_BANKS]  read data valid.
REQ-016 SHALL have port r_data_o  output  [NB_BANKS][DATA_WIDTH]  read data.
REQ-017 SHALL have port err_o  output  [NB_BANKS]  read parity error, qualified by r_valid_o.
REQ-018 SHALL have port ready_o  output  1  high only in state READY.

Function
REQ-019 Word index SHALL be add_i[$clog2(BANK_SIZE)+$clog2(DATA_WIDTH/8)-1 : $clog2(DATA_WIDTH/8)]; upper bits ignored.
REQ-020 FSM states: INIT, READY, PWDN; one FSM shared by all banks.
REQ-021 INIT: counter sweeps 0..BANK_SIZE-1, one word per cycle, all banks in parallel, full byte enable, data INIT_VALUE; after word BANK_SIZE-1 -> READY (sweep = BANK_SIZE cycles).
REQ-022 READY: gnt_o = req_i combinationally; granted access goes to bank same cycle.
REQ-023 Read granted in cycle N -> r_valid_o=1 and r_data_o valid in cycle N+1 only; writes produce no r_valid_o.
REQ-024 READY + init_req_i -> INIT, counter cleared; request in that cycle still served.
REQ-025 READY + pwdn_i -> PWDN; request in that cycle still served.
REQ-026 PWDN: banks not enabled; pwdn_i low -> INIT (contents deemed lost).
REQ-027 INIT and PWDN: gnt_o=0, no user access reaches banks; init_req_i in INIT restarts counter at 0; pwdn_i in INIT -> PWDN.
REQ-028 Partial write: only bytes with be_i=1 updated.
REQ-029 Read of a word never written since last sweep SHALL return INIT_VALUE.

Reset
REQ-030 rst_i asserted (any cycle, mid-sweep included): state INIT, counter 0, gnt_o=0, r_valid_o=0, err_o=0, ready_o=0, r_data_o=0 register.
REQ-031 Sweep starts first clock after rst_i deasserts; bank contents not reset.

Configuration
REQ-032 Macro TCDM_BANK_PARITY_EN defined: each bank stores DATA_WIDTH+DATA_WIDTH/8 bits, one even-parity bit per byte written with its byte (sweep included); read checks all bytes, err_o=1 with r_valid_o on any mismatch.
REQ-033 Macro undefined: storage DATA_WIDTH bits, err_o tied 0, no parity logic.

Structure
REQ-034 Package tcdm_bank_array_pkg SHALL hold FSM state enum and parity-width helper function.
REQ-035 Sub-module tcdm_bank_init_fsm SHALL hold FSM and sweep counter; banks instantiated as tc_sram (Latency 1) in a generate loop.

Verification
REQ-036 Reset release, NB_BANKS=4, BANK_SIZE=16, INIT_VALUE=32'hA5A5A5A5 -> gnt_o=0 16 cycles, then ready_o=1; read bank 2 addr 0x3C -> 32'hA5A5A5A5 next cycle.
REQ-037 READY, write bank 1 addr 0x08 data 32'h12345678 be 4'b0101, read back -> 32'hA534A578.
REQ-038 pwdn_i high 5 cycles then low -> gnt_o=0 throughout plus 16 sweep cycles; previously written word reads INIT_VALUE.
REQ-039 rst_i pulsed at sweep count 7 -> sweep restarts at 0, ready_o rises exactly 16 cycles after deassert.
REQ-040 TCDM_BANK_PARITY_EN, force-flip stored bit 9 of bank 0 word 3, read -> r_valid_o=1, err_o[0]=1; clean read -> err_o=0.
REQ-041 All banks read simultaneously back-to-back 16 cycles -> gnt_o all-ones, r_valid_o every cycle, data per address correct.
